// File: rtl/acc_mem_pkg.sv
// Shared definitions for the memory read arbiter: requester tags and their width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_mem_pkg;

    typedef enum logic {
        TAG_DATA   = 1'b0,
        TAG_WEIGHT = 1'b1
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Round-robin pick on a conflict: serve whoever did not win last time.
    function automatic tag_t rr_pick(input tag_t last_gnt);
        return (last_gnt == TAG_DATA) ? TAG_WEIGHT : TAG_DATA;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per issued-but-unreturned read.
// Latency: a pushed tag reaches the head on the next cycle; count updates one cycle after push/pop.
// Backpressure: push is ignored when full and pop when empty; same-cycle push+pop keeps the count.
module tag_fifo
    import acc_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  tag_t                     push_tag,
    input  logic                     pop,
    output tag_t                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tag_t             slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one BRAM read port between the data and weight fetch engines and routes returns by tag.
// Latency: grant is combinational, memory request one cycle after grant, return routing zero cycles.
// Backpressure: requesters hold rden/addr until granted; no grant while MAX_OUTST reads are in flight.
module mem_rd_arbiter
    import acc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        i_d_addr,
    input  logic                         i_d_rden,
    output logic                         o_d_gnt,
    output logic [DATA_WIDTH-1:0]        o_d_dat,
    output logic                         o_d_val,
    input  logic [ADDR_WIDTH-1:0]        i_w_addr,
    input  logic                         i_w_rden,
    output logic                         o_w_gnt,
    output logic [DATA_WIDTH-1:0]        o_w_dat,
    output logic                         o_w_val,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    output logic                         o_mem_rden,
    input  logic [DATA_WIDTH-1:0]        i_mem_dat,
    input  logic                         i_mem_val,
    output logic [$clog2(MAX_OUTST):0]   o_outst,
    output logic                         o_err
);

    tag_t                  last_gnt;
    tag_t                  fifo_head;
    tag_t                  push_tag;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  can_issue;
    logic                  push;
    logic                  pop;
    logic                  ret_ok;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    // A return in the same cycle does not free a slot: the full check uses the current count.
    assign can_issue = ~fifo_full & ~rst;

    always_comb begin
        o_d_gnt = 1'b0;
        o_w_gnt = 1'b0;
        if (can_issue) begin
            if (i_d_rden && i_w_rden) begin
                if (RR_EN && rr_pick(last_gnt) == TAG_WEIGHT) begin
                    o_w_gnt = 1'b1;
                end else begin
                    o_d_gnt = 1'b1;
                end
            end else if (i_d_rden) begin
                o_d_gnt = 1'b1;
            end else if (i_w_rden) begin
                o_w_gnt = 1'b1;
            end
        end
    end

    assign push     = o_d_gnt | o_w_gnt;
    assign push_tag = o_w_gnt ? TAG_WEIGHT : TAG_DATA;
    assign gnt_addr = o_w_gnt ? i_w_addr : i_d_addr;

    // Returns come back in issue order, so the FIFO head always names the owner.
    assign ret_ok  = i_mem_val & ~fifo_empty & ~rst;
    assign pop     = ret_ok;
    assign o_d_dat = i_mem_dat;
    assign o_w_dat = i_mem_dat;
    assign o_d_val = ret_ok & (fifo_head == TAG_DATA);
    assign o_w_val = ret_ok & (fifo_head == TAG_WEIGHT);

    tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (fifo_head),
        .count    (o_outst),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mem_rden <= 1'b0;
            o_mem_addr <= '0;
            last_gnt   <= TAG_WEIGHT;
            o_err      <= 1'b0;
        end else begin
            o_mem_rden <= push;
            if (push) begin
                o_mem_addr <= gnt_addr;
                last_gnt   <= push_tag;
            end
            // A word with no owner is dropped; flag it until the next reset.
            if (i_mem_val && fifo_empty) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) driven by requester and BRAM models.
// Latency: memory model answers LAT cycles after each issued read, in order.
// Backpressure: requesters hold until granted; memory model can stall returns.
module tb_mem_rd_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MO  = 4;
    localparam int CW  = $clog2(MO) + 1;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] d_addr   [2];
    logic [AW-1:0] w_addr   [2];
    logic [AW-1:0] mem_addr [2];
    logic          d_rden   [2];
    logic          w_rden   [2];
    logic          d_gnt    [2];
    logic          w_gnt    [2];
    logic          d_val    [2];
    logic          w_val    [2];
    logic          mem_rden [2];
    logic          mem_val  [2];
    logic          err      [2];
    logic [DW-1:0] d_dat    [2];
    logic [DW-1:0] w_dat    [2];
    logic [DW-1:0] mem_dat  [2];
    logic [CW-1:0] outst    [2];

    always #5 clk = ~clk;

    // Lane 0 is round-robin, lane 1 gives data fixed priority.
    for (genvar g = 0; g < 2; g++) begin : lane
        mem_rd_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MAX_OUTST  (MO),
            .RR_EN      (g == 0)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .i_d_addr   (d_addr[g]),
            .i_d_rden   (d_rden[g]),
            .o_d_gnt    (d_gnt[g]),
            .o_d_dat    (d_dat[g]),
            .o_d_val    (d_val[g]),
            .i_w_addr   (w_addr[g]),
            .i_w_rden   (w_rden[g]),
            .o_w_gnt    (w_gnt[g]),
            .o_w_dat    (w_dat[g]),
            .o_w_val    (w_val[g]),
            .o_mem_addr (mem_addr[g]),
            .o_mem_rden (mem_rden[g]),
            .i_mem_dat  (mem_dat[g]),
            .i_mem_val  (mem_val[g]),
            .o_outst    (outst[g]),
            .o_err      (err[g])
        );
    end

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // ---------------- scoreboard / reference model (monitor side) ----------------
    int          total = 0;
    int          bad   = 0;
    logic [32:0] sb [2][$];
    bit          m_last  [2] = '{1'b1, 1'b1};
    bit          m_iss_v [2] = '{1'b0, 1'b0};
    logic [31:0] m_iss_a [2] = '{32'd0, 32'd0};
    bit          m_err   [2] = '{1'b0, 1'b0};
    int          t_gd [2] = '{0, 0};
    int          t_gw [2] = '{0, 0};
    int          t_vd [2] = '{0, 0};
    int          t_vw [2] = '{0, 0};
    int          chk_seq = 0;
    int          seen_seq = 0;
    int          x_gd, x_gw, x_vd, x_vw, x_os, x_er;

    task automatic chk(input string nm, input int l, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s lane%0d t=%0t got=%0h want=%0h", nm, l, $time, act, want);
        end
    endtask

    logic        ed, ew, evd, evw, spurious, do_tally;
    logic [31:0] edat, gaddr;
    logic [32:0] e;

    always @(negedge clk) begin
        do_tally = (chk_seq != seen_seq);
        seen_seq = chk_seq;
        for (int l = 0; l < 2; l++) begin
            if (do_tally) begin
                chk("d_grants", l, 64'(t_gd[l]), 64'(x_gd));
                chk("w_grants", l, 64'(t_gw[l]), 64'(x_gw));
                chk("d_returns", l, 64'(t_vd[l]), 64'(x_vd));
                chk("w_returns", l, 64'(t_vw[l]), 64'(x_vw));
                chk("outst_point", l, 64'(outst[l]), 64'(x_os));
                chk("err_point", l, 64'(err[l]), 64'(x_er));
                t_gd[l] = 0; t_gw[l] = 0; t_vd[l] = 0; t_vw[l] = 0;
            end
            // Expected grant from the arbitration rules and the in-flight count.
            ed = 1'b0;
            ew = 1'b0;
            if (!rst && sb[l].size() < MO) begin
                if (d_rden[l] && w_rden[l]) begin
                    ed = (l == 1) || m_last[l];
                    ew = !ed;
                end else begin
                    ed = d_rden[l];
                    ew = w_rden[l];
                end
            end
            chk("grant", l, 64'({d_gnt[l], w_gnt[l]}), 64'({ed, ew}));
            chk("mem_rden", l, 64'(mem_rden[l]), 64'(m_iss_v[l]));
            chk("mem_addr", l, 64'(mem_addr[l]), 64'(m_iss_a[l]));
            chk("outst", l, 64'(outst[l]), 64'(sb[l].size()));
            chk("err", l, 64'(err[l]), 64'(m_err[l]));

            evd = 1'b0; evw = 1'b0; edat = '0; spurious = 1'b0;
            if (!rst && mem_val[l]) begin
                if (sb[l].size() == 0) begin
                    spurious = 1'b1;
                end else begin
                    e    = sb[l].pop_front();
                    evw  = e[32];
                    evd  = !e[32];
                    edat = fdat(e[31:0]);
                end
            end
            chk("ret_val", l, 64'({d_val[l], w_val[l]}), 64'({evd, evw}));
            if (evd) chk("d_dat", l, 64'(d_dat[l]), 64'(edat));
            if (evw) chk("w_dat", l, 64'(w_dat[l]), 64'(edat));

            t_gd[l] += int'(d_gnt[l]);
            t_gw[l] += int'(w_gnt[l]);
            t_vd[l] += int'(d_val[l]);
            t_vw[l] += int'(w_val[l]);

            if (rst) begin
                sb[l].delete();
                m_last[l]  = 1'b1;
                m_iss_v[l] = 1'b0;
                m_iss_a[l] = '0;
                m_err[l]   = 1'b0;
            end else begin
                m_iss_v[l] = ed | ew;
                if (ed | ew) begin
                    gaddr      = ed ? d_addr[l] : w_addr[l];
                    m_iss_a[l] = gaddr;
                    sb[l].push_back({ew, gaddr});
                    m_last[l]  = ew;
                end
                if (spurious) m_err[l] = 1'b1;
            end
        end
    end

    // ---------------- stimulus: requesters and BRAM model ----------------
    int          cycle = 0;
    int          d_left [2];
    int          w_left [2];
    bit          dg [2];
    bit          wg [2];
    bit          gaps = 0, rnd_addr = 0, rnd_stall = 0, stall = 0, spur = 0;
    logic [31:0] pa [2][$];
    int          pd [2][$];

    task automatic cyc();
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            dg[l] = d_gnt[l];
            wg[l] = w_gnt[l];
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int l = 0; l < 2; l++) begin
            if (dg[l]) begin
                d_left[l]--;
                d_addr[l] = rnd_addr ? $urandom : d_addr[l] + 32'd1;
            end
            if (!d_rden[l] || dg[l])
                d_rden[l] = !rst && d_left[l] > 0 && (!gaps || $urandom_range(0, 3) != 0);
            if (wg[l]) begin
                w_left[l]--;
                w_addr[l] = rnd_addr ? $urandom : w_addr[l] + 32'd1;
            end
            if (!w_rden[l] || wg[l])
                w_rden[l] = !rst && w_left[l] > 0 && (!gaps || $urandom_range(0, 3) != 0);

            mem_val[l] = 1'b0;
            mem_dat[l] = $urandom;
            if (rst) begin
                pa[l].delete();
                pd[l].delete();
            end else begin
                if (mem_rden[l]) begin
                    pa[l].push_back(mem_addr[l]);
                    pd[l].push_back(cycle + LAT);
                end
                if (pa[l].size() > 0 && pd[l][0] <= cycle &&
                    !stall && !(rnd_stall && $urandom_range(0, 2) == 0)) begin
                    mem_val[l] = 1'b1;
                    mem_dat[l] = fdat(pa[l].pop_front());
                    void'(pd[l].pop_front());
                end else if (spur && pa[l].size() == 0) begin
                    mem_val[l] = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_req(input int nd, input int nw, input logic [31:0] da, input logic [31:0] wa);
        for (int l = 0; l < 2; l++) begin
            d_left[l] = nd; d_addr[l] = da; d_rden[l] = (nd > 0);
            w_left[l] = nw; w_addr[l] = wa; w_rden[l] = (nw > 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        stall = 0;
        spur = 0;
        set_req(0, 0, 32'd0, 32'd0);
        run(n);
        rst = 1'b0;
    endtask

    task automatic expect_t(input int gd, input int gw, input int vd, input int vw, input int os, input int er);
        x_gd = gd; x_gw = gw; x_vd = vd; x_vw = vw; x_os = os; x_er = er;
        chk_seq++;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            d_rden[l] = 1'b0; w_rden[l] = 1'b0;
            d_addr[l] = '0;   w_addr[l] = '0;
            mem_val[l] = 1'b0; mem_dat[l] = '0;
            d_left[l] = 0;    w_left[l] = 0;
        end
        do_reset(2);

        // Data only, 8 back-to-back reads from address 0.
        set_req(8, 0, 32'd0, 32'd0);
        run(16);
        expect_t(8, 0, 8, 0, 0, 0);

        // Both requesting continuously.
        do_reset(1);
        set_req(6, 6, 32'h0000_0100, 32'h8000_0000);
        run(20);
        expect_t(6, 6, 6, 6, 0, 0);

        // Returns stalled: grants stop at MAX_OUTST, then resume one per return.
        do_reset(1);
        stall = 1;
        set_req(6, 0, 32'h0000_0200, 32'd0);
        run(8);
        expect_t(4, 0, 0, 0, 4, 0);
        stall = 0;
        run(14);
        expect_t(2, 0, 6, 0, 0, 0);

        // Return with nothing outstanding: dropped, sticky error.
        spur = 1;
        cyc();
        spur = 0;
        run(4);
        expect_t(0, 0, 0, 0, 0, 1);

        // Reset with three reads in flight, then a fresh conflict.
        do_reset(1);
        stall = 1;
        set_req(3, 0, 32'h0000_0300, 32'd0);
        run(6);
        expect_t(3, 0, 0, 0, 3, 0);
        do_reset(1);
        set_req(2, 2, 32'h0000_0400, 32'h9000_0000);
        run(12);
        expect_t(2, 2, 2, 2, 0, 0);

        // Randomised traffic with gaps and return stalls.
        do_reset(1);
        gaps = 1; rnd_addr = 1; rnd_stall = 1;
        set_req(40, 40, $urandom, $urandom);
        run(400);
        gaps = 0; rnd_stall = 0;
        run(20);
        expect_t(40, 40, 40, 40, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
